cpu_obi_port_arbiter: RTL
=========================

# cpu_obi_port_arbiter

Two-to-one OBI arbiter that lets the CPU subsystem's instruction and data ports share a single OBI master port, for memory-reduced configurations with only one crossbar slot per core. It sits between the core's instruction/data OBI interfaces and the bus. It grants requests round-robin and locks the choice until the bus accepts the request. It tracks outstanding transactions in order, so each `rvalid` is routed back to the port that issued the request.

## Interface
- `MAX_OUTSTANDING`, default 2: depth of the in-order ID FIFO, i.e. the maximum number of transactions granted but not yet answered; legal range 1..8.
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `instr_req_i` input `obi_req_t`: core instruction request.
- `instr_resp_o` output `obi_resp_t`: instruction response (`gnt`, `rvalid`, `rdata`).
- `data_req_i` input `obi_req_t`: core data request.
- `data_resp_o` output `obi_resp_t`: data response.
- `mem_req_o` output `obi_req_t`: shared request toward the bus.
- `mem_resp_i` input `obi_resp_t`: bus response.
- `spurious_rvalid_o` output 1: one-cycle pulse when `mem_resp_i.rvalid` arrives with no outstanding transaction.

## Operation
- **State registers:**
  - `last_q`: ID of the last granted master. Reset value is DATA, so INSTR wins the first conflict.
  - `lock_q`: set while a forwarded request is waiting for `gnt`. Reset value is 0.
  - `lock_id_q`: ID of the locked master.
  - ID FIFO with count `cnt_q`. Resets empty, `cnt_q`=0.
- **Selection (combinational, same cycle):**
  - If `lock_q` is set, select `lock_id_q`, regardless of the other requester.
  - Else, if only one master requests, select it.
  - Else, if both request, select the master that is not `last_q`.
- **Blocking:** if `cnt_q == MAX_OUTSTANDING`, `mem_req_o.req`=0 and both `gnt` outputs are 0. The decision uses the registered count only; an `rvalid` in the same cycle does not unblock.
- **Forwarding:** `mem_req_o` carries all fields of the selected master. When nothing is selected, `mem_req_o` is all-zero.
- **Grant path:**
  - The selected master's `gnt` = `mem_resp_i.gnt`; the other master's `gnt` = 0.
  - On a handshake (`req`&&`gnt`): push the selected ID into the FIFO, update `last_q`, clear `lock_q`.
  - If `mem_req_o.req` && !`mem_resp_i.gnt`: set `lock_q` and store `lock_id_q`. OBI requires the address phase to stay stable until granted.
- **Response path:**
  - `rdata` from `mem_resp_i` is fanned out to both ports.
  - `rvalid` goes only to the port named by the FIFO head; then pop.
  - A push and a pop in the same cycle leave `cnt_q` unchanged.
  - `rvalid` with an empty FIFO: no pop, no `rvalid` to either port, and `spurious_rvalid_o`=1 for that cycle.
- **Protocol assumptions:** the bus answers in order. `gnt` without `req` is ignored.

## Timing
- Request-to-grant and `rvalid` routing are purely combinational: zero added latency and no bubble cycles.
- Back-to-back grants are allowed every cycle until the FIFO is full.
- **Reset values of outputs:** `mem_req_o`=0, both `gnt`=0, both `rvalid`=0, `spurious_rvalid_o`=0. `rdata` follows `mem_resp_i`.
- **Reset mid-transaction:** all state clears immediately (asynchronous). Responses arriving after reset count as spurious.
- **Wrap-around:** FIFO read/write pointers are `$clog2(MAX_OUTSTANDING)` bits, or 1 bit when `MAX_OUTSTANDING`=1. They wrap modulo `MAX_OUTSTANDING`; `cnt_q` is one bit wider.

## Structure
- Package `cpu_arb_pkg`:
  - `typedef enum logic {MST_INSTR=1'b0, MST_DATA=1'b1} cpu_arb_mst_e`.
  - Constant `CpuArbMaxOutstandingLimit = 8`.
- Sub-module `cpu_arb_id_fifo`: parameterised depth, 1-bit payload, push/pop/full/empty/head outputs, same-cycle push+pop supported, async active-low reset.
- Top level: selection/lock logic and response demux only.

## Test plan
- **Single port:** instr-only request, addr `0x180`, `gnt` same cycle, `rvalid` 1 cycle later with `rdata=0xDEADBEEF` -> `instr_resp_o.gnt`=1 in cycle 0, `instr_resp_o.rvalid`=1 with `0xDEADBEEF` in cycle 1, `data_resp_o.rvalid`=0 throughout.
- **Round-robin:** both ports request continuously, bus grants every cycle -> grants alternate INSTR, DATA, INSTR, DATA starting from reset, and rvalids route in the same order.
- **Lock:** both request, bus holds `gnt`=0 for 3 cycles, then data request drops and re-rises -> INSTR stays selected and `mem_req_o.addr` is stable all 4 cycles; DATA is granted only after the INSTR handshake.
- **Full:** with `MAX_OUTSTANDING`=2, two grants with no `rvalid` -> a third request sees `mem_req_o.req`=0. An `rvalid` in the same cycle still blocks; the next cycle forwards.
- **Spurious response:** `rvalid` after reset with the FIFO empty -> `spurious_rvalid_o` pulses 1 cycle, neither port sees `rvalid`, and `cnt_q` stays 0.
- **Async reset:** `rst_ni` asserted with 2 outstanding transactions while locked -> all outputs go to reset values without waiting for a clock edge, and the next request is granted INSTR-first.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: master IDs, OBI channel structs and limits shared by the
// instruction/data port arbiter and its ID FIFO.
package cpu_arb_pkg;
   typedef enum logic {MST_INSTR = 1'b0, MST_DATA = 1'b1} cpu_arb_mst_e;
   localparam int unsigned CpuArbMaxOutstandingLimit = 8;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;
   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

// File: rtl/cpu_arb_id_fifo.sv
// cpu_arb_id_fifo: in-order FIFO of granted master IDs, one entry per
// outstanding transaction; push and pop may happen in the same cycle.
module cpu_arb_id_fifo #(
   parameter int unsigned Depth = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic full,
   output logic empty,
   output logic head
);
   localparam int unsigned PtrW = (Depth == 1) ? 1 : $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthC = CntW'(Depth);
   logic [Depth-1:0] mem_q;
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] cnt_q;
   logic do_push, do_pop;
   assign full = cnt_q == DepthC;
   assign empty = cnt_q == '0;
   assign head = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din;
            wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
         end
         if (do_pop) rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
         cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end
endmodule

// File: rtl/cpu_obi_port_arbiter.sv
// cpu_obi_port_arbiter: shares one OBI master port between the core's
// instruction and data ports; round-robin with grant lock, in-order rvalid demux.
module cpu_obi_port_arbiter
   import cpu_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  obi_req_t  instr_req_i,
   output obi_resp_t instr_resp_o,
   input  obi_req_t  data_req_i,
   output obi_resp_t data_resp_o,
   output obi_req_t  mem_req_o,
   input  obi_resp_t mem_resp_i,
   output logic      spurious_rvalid_o
);
   cpu_arb_mst_e last_q, lock_id_q, sel;
   logic lock_q, any_req, full, empty, head, hs, rv;
   always_comb begin
      any_req = lock_q || instr_req_i.req || data_req_i.req;
      // A pending ungranted request keeps the port until the bus accepts it
      sel = lock_q ? lock_id_q
          : (instr_req_i.req && data_req_i.req) ? (last_q == MST_INSTR ? MST_DATA : MST_INSTR)
          : instr_req_i.req ? MST_INSTR : MST_DATA;
      mem_req_o = (any_req && !full) ? (sel == MST_DATA ? data_req_i : instr_req_i) : '0;
      hs = mem_req_o.req && mem_resp_i.gnt;
      rv = mem_resp_i.rvalid && !empty;
      instr_resp_o.gnt = hs && sel == MST_INSTR;
      instr_resp_o.rvalid = rv && head == MST_INSTR;
      instr_resp_o.rdata = mem_resp_i.rdata;
      data_resp_o.gnt = hs && sel == MST_DATA;
      data_resp_o.rvalid = rv && head == MST_DATA;
      data_resp_o.rdata = mem_resp_i.rdata;
      spurious_rvalid_o = mem_resp_i.rvalid && empty;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= MST_DATA;
         lock_q <= 1'b0;
         lock_id_q <= MST_INSTR;
      end else if (hs) begin
         last_q <= sel;
         lock_q <= 1'b0;
      end else if (mem_req_o.req) begin
         lock_q <= 1'b1;
         lock_id_q <= sel;
      end
   end
   cpu_arb_id_fifo #(.Depth(MAX_OUTSTANDING)) u_id_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (hs),
      .pop   (rv),
      .din   (sel),
      .full  (full),
      .empty (empty),
      .head  (head)
   );
endmodule
